// File: rtl/shift_iter_pkg.sv
// Shared constants for the iterative shifter: mode encodings and FSM states.
package shift_pkg;
  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/shift_iter_if.sv
// Operand and result handshakes of the iterative shifter.
interface shift_iter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );
  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/shift_iter_step.sv
// Combinational single-step shifter: moves a word by 0..MAX_STEP positions.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 3,
  parameter int STEP_W   = $clog2(MAX_STEP + 1)
) (
  input  logic [WIDTH-1:0]  i_data,
  input  logic [STEP_W-1:0] i_step,
  input  logic [1:0]        i_mode,
  input  logic              i_sign,
  output logic [WIDTH-1:0]  o_data
);
  logic [2*WIDTH-1:0] w_rot;
  logic [WIDTH-1:0]   w_fill;

  // Select the shifted word; ASR fills with the caller-held sign so the
  // original sign survives every step, ROL wraps via a doubled word.
  always_comb begin
    w_rot  = {i_data, i_data} << i_step;
    w_fill = i_sign ? ~({WIDTH{1'b1}} >> i_step) : '0;
    o_data = i_data;
    case (i_mode)
      MODE_LSL: o_data = i_data << i_step;
      MODE_LSR: o_data = i_data >> i_step;
      MODE_ASR: o_data = (i_data >> i_step) | w_fill;
      default:  o_data = w_rot[2*WIDTH-1:WIDTH];
    endcase
  end
endmodule

// File: rtl/shift_iter.sv
// Iterative shifter/rotator: applies up to MAX_STEP positions per clock
// until the requested amount is consumed, then holds the result.
module shift_iter
  import shift_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_STEP = 3,
  parameter int AMT_W    = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  shift_iter_if.slave    bus,
  output logic           busy
);
  localparam int               STEP_W   = $clog2(MAX_STEP + 1);
  localparam logic [AMT_W-1:0] AMT_MAX  = AMT_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(MAX_STEP);

  state_t              r_state, w_next;
  logic [WIDTH-1:0]    r_data, r_out, w_shifted;
  logic [1:0]          r_mode;
  logic                r_sign, r_zero;
  logic [AMT_W-1:0]    r_rem, w_amt, w_rem_nxt;
  logic [STEP_W-1:0]   w_step;
  logic                w_accept;

  // Out-of-range amounts only exist for non power-of-two widths.
  assign w_amt     = (bus.in_amt > AMT_MAX) ? AMT_MAX : bus.in_amt;
  assign w_step    = (r_rem > STEP_MAX) ? STEP_W'(MAX_STEP) : STEP_W'(r_rem);
  assign w_rem_nxt = r_rem - AMT_W'(w_step);
  assign w_accept  = (r_state == ST_IDLE) && bus.in_valid && !flush;

  shift_step #(.WIDTH(WIDTH), .MAX_STEP(MAX_STEP)) u_step (
    .i_data (r_data),
    .i_step (w_step),
    .i_mode (r_mode),
    .i_sign (r_sign),
    .o_data (w_shifted)
  );

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = (w_amt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (w_rem_nxt == '0) w_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Working word, remaining count and result register. The result is only
  // written on entry to DONE so it stays put through flush and backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_mode <= MODE_LSL;
      r_sign <= 1'b0;
      r_rem  <= '0;
      r_out  <= '0;
      r_zero <= 1'b1;
    end else if (flush) begin
      r_rem  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_data <= bus.in_data;
          r_mode <= bus.in_mode;
          r_sign <= bus.in_data[WIDTH-1];
          r_rem  <= w_amt;
          if (w_amt == '0) begin
            r_out  <= bus.in_data;
            r_zero <= (bus.in_data == '0);
          end
        end
        ST_SHIFT: begin
          r_data <= w_shifted;
          r_rem  <= w_rem_nxt;
          if (w_rem_nxt == '0) begin
            r_out  <= w_shifted;
            r_zero <= (w_shifted == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_out;
  assign bus.out_zero  = r_zero;
  assign busy          = (r_state != ST_IDLE);
endmodule

// File: doc/shift_iter.md
Name: shift_iter

Overview:
- Parametrised iterative shifter/rotator that generalises the 4-bit 0..3 position shifter slice.
- Accepts a word, a shift amount and a mode over a valid/ready handshake.
- Shifts by at most MAX_STEP positions per clock until the full amount is applied, then presents the result over a second valid/ready handshake.
- Used by the datapath wherever a full barrel shifter would cost too much area.

Parameters:
- WIDTH, 32, data word width in bits (>=4).
- MAX_STEP, 3, maximum positions shifted per clock (1..WIDTH-1).
- AMT_W, $clog2(WIDTH), width of shift amount.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of any operation in progress.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept operand.
- in_data  input  WIDTH  word to shift.
- in_amt  input  AMT_W  shift amount, 0..WIDTH-1.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0.
- busy  output  1  state != IDLE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_zero=1, busy=0, internal remaining count=0. Reset applies mid-operation; the operand in flight is discarded with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, register data, mode and remaining=in_amt. Go to SHIFT if in_amt!=0, else DONE.
  - SHIFT: each cycle step=min(remaining,MAX_STEP); data <= step_shift(data,step,mode); remaining -= step. When the new remaining is 0, go to DONE.
  - DONE: out_valid=1, with out_data and out_zero stable. On out_ready, go to IDLE. Otherwise hold every output unchanged indefinitely.
- Latency: out_valid rises 1+ceil(in_amt/MAX_STEP) cycles after the accept edge. For amt 0 that is 1 cycle.
- Throughput: one operation in flight. in_ready=0 in SHIFT and DONE. There is no accept on the same cycle as the out handshake; IDLE is always visited for at least one cycle.
- Mode semantics per step of s positions:
  - LSL: zero fill at the LSB.
  - LSR: zero fill at the MSB.
  - ASR: fill with the original sign bit, which is constant across steps.
  - ROL: bits leaving the MSB enter at the LSB.
- Right rotate is not a separate mode. The caller issues ROL by WIDTH-n.
- in_amt >= WIDTH is impossible by width when WIDTH is a power of 2. Otherwise the value is clamped to WIDTH-1 at accept.
- flush: a synchronous return to IDLE from any state with out_valid=0. out_data keeps its last value. Priority order is reset > flush > handshakes. flush in IDLE while in_valid is asserted: the operand is not accepted.
- out_zero is computed on the registered result and is valid only while out_valid=1.

Decomposition:
- Package shift_pkg holds:
  - mode constants MODE_LSL=2'b00, MODE_LSR=2'b01, MODE_ASR=2'b10, MODE_ROL=2'b11;
  - FSM state encoding ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step is a combinational WIDTH-bit shifter by 0..MAX_STEP positions with a mode input and a fill/sign input. It is the parametrised form of the existing 4-bit slice and is instantiated once inside shift_iter.
- FSM, remaining counter and output registers live in shift_iter.

Test Plan:
- WIDTH=32, MAX_STEP=3. Accept 0x80000001, amt=4, ASR -> out_data=0xF8000000, out_zero=0, out_valid exactly 3 cycles after accept.
- ROL 0x00000001 by 31 -> 0x80000000 after 12 cycles; ROL 0x12345678 by 0 -> 0x12345678 after 1 cycle.
- LSR 0x0000000F by 4 -> 0x00000000 with out_zero=1; LSL 0x0000000F by 28 -> 0xF0000000 after 11 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data/out_valid stable, in_ready=0, a new in_valid is ignored. Release -> IDLE next cycle, in_ready=1.
- Assert reset, then separately flush, 2 cycles into an amt=30 SHIFT.
  - Required next cycle: state IDLE, out_valid=0, in_ready=1.
  - After reset: out_data=0.
  - A following LSL 0x1 by 1 returns 0x2 correctly.
- Randomised sweep of all amounts 0..31 × 4 modes against a reference model. Also repeat with MAX_STEP=1 and WIDTH=36 (amt clamp 35).
